// File: rtl/neuron_update_scheduler.sv
// neuron_update_scheduler
// Runs one leaky integrate-and-fire timestep over NEURON_COUNT neurons.
// Owns both ports of the neuron state memory. Pointer ptr issues read
// addresses (stage 0), and stage 1 lines up with the returned state word.
// The input-current beat for the neuron in stage 1 is consumed when fire is
// high. The updated state and any spike are registered on that same edge.
//
// Handshakes: a beat transfers on a rising clk edge where valid && ready.
// On the current stream, ready does not depend on valid. The spike output
// holds its address stable while valid && !ready. Once a spike is raised it
// is never withdrawn until it has been accepted.
module neuron_update_scheduler #(
    parameter int NEURON_COUNT = 10000,
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 8,
    parameter int FSM_WIDTH    = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_start,
    input  logic [DATA_WIDTH-1:0]               i_threshold,
    input  logic [DATA_WIDTH-1:0]               i_leak,
    input  logic [DATA_WIDTH-1:0]               i_reset_v,
    input  logic [DATA_WIDTH-1:0]               i_refrac_period,
    input  logic                                i_in_valid,
    input  logic [DATA_WIDTH-1:0]               i_in_data,
    output logic                                o_in_ready,
    output logic                                o_spike_valid,
    output logic [ADDR_WIDTH-1:0]               o_spike_addr,
    input  logic                                i_spike_ready,
    output logic [ADDR_WIDTH-1:0]               o_mem_read_addr,
    input  logic [2*DATA_WIDTH+FSM_WIDTH-1:0]   i_mem_read_data,
    output logic                                o_mem_write_en,
    output logic [ADDR_WIDTH-1:0]               o_mem_write_addr,
    output logic [2*DATA_WIDTH+FSM_WIDTH-1:0]   o_mem_write_data,
    output logic                                o_busy,
    output logic                                o_done,
    output logic [15:0]                         o_spike_count,
    output logic [1:0]                          o_dbg_state
);

    localparam int STATE_WIDTH = 2 * DATA_WIDTH + FSM_WIDTH;
    localparam int SUM_WIDTH   = DATA_WIDTH + 2;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NEURON_COUNT - 1);
    localparam logic [FSM_WIDTH-1:0]  MODE_INTEGRATE = '0;
    localparam logic [FSM_WIDTH-1:0]  MODE_REFRACT   = FSM_WIDTH'(1);
    localparam logic signed [SUM_WIDTH-1:0] SAT_MAX = SUM_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [SUM_WIDTH-1:0] SAT_MIN = SUM_WIDTH'(-(1 << (DATA_WIDTH - 1)));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    sched_state_t state, state_next;

    // Timestep configuration, captured when a start is accepted
    logic signed [DATA_WIDTH-1:0] thr_q;
    logic        [DATA_WIDTH-1:0] leak_q;
    logic        [DATA_WIDTH-1:0] reset_v_q;
    logic        [DATA_WIDTH-1:0] refrac_q;

    // Pipeline
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  s1_valid;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic                  fire;
    logic                  advance;
    logic                  issue;
    logic                  start_accept;

    // Neuron datapath
    logic signed [DATA_WIDTH-1:0] cur_v;
    logic        [DATA_WIDTH-1:0] cur_r;
    logic        [FSM_WIDTH-1:0]  cur_mode;
    logic signed [SUM_WIDTH-1:0]  v_ext;
    logic signed [SUM_WIDTH-1:0]  leak_ext;
    logic signed [SUM_WIDTH-1:0]  in_ext;
    logic signed [SUM_WIDTH-1:0]  sum;
    logic signed [DATA_WIDTH-1:0] t;
    logic        [DATA_WIDTH-1:0] new_v;
    logic        [DATA_WIDTH-1:0] new_r;
    logic        [FSM_WIDTH-1:0]  new_mode;
    logic                         new_spike;

    assign start_accept = (state == ST_IDLE) && i_start;
    assign o_in_ready   = s1_valid && (!o_spike_valid || i_spike_ready);
    assign fire         = s1_valid && i_in_valid && o_in_ready;
    assign advance      = !s1_valid || fire;
    assign issue        = advance && (state == ST_SWEEP);
    // A stalled neuron is re-read so its state word stays on i_mem_read_data
    assign o_mem_read_addr = advance ? ptr : s1_addr;

    assign o_busy      = (state == ST_SWEEP) || (state == ST_DRAIN);
    assign o_done      = (state == ST_DONE);
    assign o_dbg_state = state;

    assign cur_v    = i_mem_read_data[STATE_WIDTH-1 -: DATA_WIDTH];
    assign cur_r    = i_mem_read_data[STATE_WIDTH-DATA_WIDTH-1 -: DATA_WIDTH];
    assign cur_mode = i_mem_read_data[FSM_WIDTH-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state: sweep until the last address is issued, then drain stage 1
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (i_start) state_next = ST_SWEEP;
            ST_SWEEP: if (issue && (ptr == LAST_ADDR)) state_next = ST_DRAIN;
            ST_DRAIN: if (!s1_valid) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Latch configuration on an accepted start only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            thr_q     <= '0;
            leak_q    <= '0;
            reset_v_q <= '0;
            refrac_q  <= '0;
        end else if (start_accept) begin
            thr_q     <= i_threshold;
            leak_q    <= i_leak;
            reset_v_q <= i_reset_v;
            refrac_q  <= i_refrac_period;
        end
    end

    // Issue pointer and stage-1 tracking; ptr returns to 0 after the last issue
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s1_addr  <= '0;
        end else begin
            if (issue) ptr <= (ptr == LAST_ADDR) ? '0 : ptr + ADDR_WIDTH'(1);
            if (advance) begin
                s1_valid <= issue;
                if (issue) s1_addr <= ptr;
            end
        end
    end

    // Saturating membrane sum v - leak + current
    always_comb begin
        v_ext    = {{2{cur_v[DATA_WIDTH-1]}}, cur_v};
        leak_ext = {2'b00, leak_q};
        in_ext   = {{2{i_in_data[DATA_WIDTH-1]}}, i_in_data};
        sum      = v_ext - leak_ext + in_ext;
        if (sum > SAT_MAX)      t = SAT_MAX[DATA_WIDTH-1:0];
        else if (sum < SAT_MIN) t = SAT_MIN[DATA_WIDTH-1:0];
        else                    t = sum[DATA_WIDTH-1:0];
    end

    // Per-neuron update: refractory countdown or integrate/threshold
    always_comb begin
        new_v     = cur_v;
        new_r     = cur_r;
        new_mode  = cur_mode;
        new_spike = 1'b0;
        if (cur_mode == MODE_REFRACT) begin
            if (cur_r <= DATA_WIDTH'(1)) begin
                new_r    = '0;
                new_mode = MODE_INTEGRATE;
            end else begin
                new_r = cur_r - DATA_WIDTH'(1);
            end
        end else if (t >= thr_q) begin
            new_spike = 1'b1;
            new_v     = reset_v_q;
            new_r     = refrac_q;
            new_mode  = (refrac_q != '0) ? MODE_REFRACT : MODE_INTEGRATE;
        end else begin
            new_v = t;
        end
    end

    // Registered write-back, spike output and saturating spike counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_mem_write_en   <= 1'b0;
            o_mem_write_addr <= '0;
            o_mem_write_data <= '0;
            o_spike_valid    <= 1'b0;
            o_spike_addr     <= '0;
            o_spike_count    <= '0;
        end else begin
            o_mem_write_en <= fire;
            if (fire) begin
                o_mem_write_addr <= s1_addr;
                o_mem_write_data <= {new_v, new_r, new_mode};
            end
            if (fire && new_spike) begin
                o_spike_valid <= 1'b1;
                o_spike_addr  <= s1_addr;
            end else if (i_spike_ready) begin
                o_spike_valid <= 1'b0;
            end
            if (start_accept) o_spike_count <= '0;
            else if (fire && new_spike && (o_spike_count != 16'hFFFF))
                o_spike_count <= o_spike_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Bench for neuron_update_scheduler: behavioural memory, current/spike
// drivers, a spike scoreboard and an integer-arithmetic neuron model.
module tb_neuron_update_scheduler;

    localparam int NC = 4;
    localparam int AW = 14;
    localparam int DW = 8;
    localparam int FW = 2;
    localparam int SW = 2 * DW + FW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic [DW-1:0] i_threshold, i_leak, i_reset_v, i_refrac_period;
    logic          i_in_valid;
    logic [DW-1:0] i_in_data;
    logic          o_in_ready;
    logic          o_spike_valid;
    logic [AW-1:0] o_spike_addr;
    logic          i_spike_ready;
    logic [AW-1:0] o_mem_read_addr;
    logic [SW-1:0] i_mem_read_data;
    logic          o_mem_write_en;
    logic [AW-1:0] o_mem_write_addr;
    logic [SW-1:0] o_mem_write_data;
    logic          o_busy, o_done;
    logic [15:0]   o_spike_count;
    logic [1:0]    o_dbg_state;

    neuron_update_scheduler #(
        .NEURON_COUNT(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FSM_WIDTH(FW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start),
        .i_threshold(i_threshold), .i_leak(i_leak), .i_reset_v(i_reset_v),
        .i_refrac_period(i_refrac_period),
        .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
        .o_spike_valid(o_spike_valid), .o_spike_addr(o_spike_addr),
        .i_spike_ready(i_spike_ready),
        .o_mem_read_addr(o_mem_read_addr), .i_mem_read_data(i_mem_read_data),
        .o_mem_write_en(o_mem_write_en), .o_mem_write_addr(o_mem_write_addr),
        .o_mem_write_data(o_mem_write_data),
        .o_busy(o_busy), .o_done(o_done), .o_spike_count(o_spike_count),
        .o_dbg_state(o_dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Behavioural state memory: 1-cycle read latency, plus a bench poke port
    logic [SW-1:0] mem [0:(1<<AW)-1];
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [SW-1:0] poke_data = '0;
    always @(posedge clk) begin
        if (o_mem_write_en) mem[o_mem_write_addr] <= o_mem_write_data;
        if (poke_en) mem[poke_addr] <= poke_data;
        i_mem_read_data <= mem[o_mem_read_addr];
    end

    // Scoreboard and model state
    logic [AW-1:0] exp_q[$];
    logic [DW-1:0] cur_q[$];
    logic [DW-1:0] cur_arr[$];
    logic [SW-1:0] ref_mem [NC];
    int cfg_thr, cfg_leak, cfg_rv, cfg_rp;
    int n_checks = 0;
    int n_pass = 0;
    int n_consumed = 0;
    int n_writes = 0;
    int gap_max = 0;
    bit rand_ready = 0;
    bit stall_arm = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Neuron rule in plain integer arithmetic
    function automatic logic [SW-1:0] ref_neuron(input logic [SW-1:0] s,
                                                 input logic [DW-1:0] cur,
                                                 output bit spk);
        int v, r, m, t;
        v = $signed(s[SW-1 -: DW]);
        r = s[SW-DW-1 -: DW];
        m = s[FW-1:0];
        spk = 0;
        if (m == 1) begin
            if (r <= 1) begin r = 0; m = 0; end
            else r = r - 1;
        end else begin
            t = v - cfg_leak + $signed(cur);
            if (t > 127) t = 127;
            if (t < -128) t = -128;
            if (t >= cfg_thr) begin
                spk = 1; v = cfg_rv; r = cfg_rp; m = (cfg_rp != 0) ? 1 : 0;
            end else begin
                v = t;
            end
        end
        return {v[DW-1:0], r[DW-1:0], m[FW-1:0]};
    endfunction

    // Driver: current stream with gaps, spike-ready pattern, spike scoreboard
    initial begin : drive_stream
        int gap;
        int stall;
        gap = 0;
        stall = 0;
        i_in_valid = 1'b0;
        i_in_data = '0;
        i_spike_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (stall_arm && o_spike_valid) begin
                stall = 5;
                stall_arm = 0;
            end
            if (stall > 0) i_spike_ready = 1'b0;
            else i_spike_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cur_q.size() > 0 && gap == 0) begin
                i_in_valid = 1'b1;
                i_in_data = cur_q[0];
            end else begin
                i_in_valid = 1'b0;
                if (gap > 0) gap--;
            end
            #1;
            if (stall > 0) begin
                check_eq("stall_in_ready", o_in_ready, 0);
                check_eq("stall_read_addr", o_mem_read_addr, n_consumed);
                if (stall < 5) check_eq("stall_no_write", o_mem_write_en, 0);
                stall--;
            end
            if (i_in_valid && o_in_ready) begin
                void'(cur_q.pop_front());
                n_consumed++;
                gap = $urandom_range(0, gap_max);
            end
            if (o_mem_write_en) n_writes++;
            if (o_spike_valid && i_spike_ready) begin
                if (exp_q.size() == 0) check_eq("spike_unexpected", exp_q.size(), 1);
                else check_eq("spike_addr", o_spike_addr, exp_q.pop_front());
            end
        end
    end

    task automatic set_neuron(input int idx, input logic [SW-1:0] w);
        @(negedge clk);
        poke_en = 1'b1;
        poke_addr = AW'(idx);
        poke_data = w;
        @(negedge clk);
        poke_en = 1'b0;
        ref_mem[idx] = w;
    endtask

    task automatic set_cfg(input int thr, input int leak, input int rv, input int rp);
        cfg_thr = thr; cfg_leak = leak; cfg_rv = rv; cfg_rp = rp;
    endtask

    task automatic set_cur4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] c, input logic [DW-1:0] d);
        cur_arr.delete();
        cur_arr.push_back(a); cur_arr.push_back(b);
        cur_arr.push_back(c); cur_arr.push_back(d);
    endtask

    task automatic rand_cur(input int extra);
        cur_arr.delete();
        for (int i = 0; i < NC + extra; i++) cur_arr.push_back(DW'($urandom_range(0, 255)));
    endtask

    task automatic drive_start();
        i_start = 1'b1;
        i_threshold = cfg_thr[DW-1:0];
        i_leak = cfg_leak[DW-1:0];
        i_reset_v = cfg_rv[DW-1:0];
        i_refrac_period = cfg_rp[DW-1:0];
    endtask

    // One timestep: model, start, wait for done, drain spikes, compare memory
    task automatic run_step(input int exp_cyc, input int extra, input bit poke_start);
        bit spk;
        bit got;
        int cyc;
        int exp_cnt;
        exp_cnt = 0;
        for (int i = 0; i < NC; i++) begin
            ref_mem[i] = ref_neuron(ref_mem[i], cur_arr[i], spk);
            if (spk) begin exp_q.push_back(AW'(i)); exp_cnt++; end
        end
        @(negedge clk);
        cur_q = cur_arr;
        n_consumed = 0;
        n_writes = 0;
        drive_start();
        @(negedge clk);
        i_start = 1'b0;
        check_eq("busy_first_cycle", o_busy, 1);
        check_eq("raddr_first_cycle", o_mem_read_addr, 0);
        cyc = 1;
        got = 0;
        while (!got && cyc < 400) begin
            if (poke_start && cyc == 3) begin
                i_start = 1'b1; i_threshold = 8'h80; i_leak = 8'hFF;
                i_reset_v = 8'h11; i_refrac_period = 8'h22;
            end else begin
                i_start = 1'b0;
            end
            if (o_done) got = 1;
            else begin @(negedge clk); cyc++; end
        end
        i_start = 1'b0;
        check_eq("done_seen", got, 1);
        if (exp_cyc > 0) check_eq("done_cycle", cyc, exp_cyc);
        check_eq("busy_at_done", o_busy, 0);
        check_eq("spike_count", o_spike_count, exp_cnt);
        @(negedge clk);
        check_eq("done_one_cycle", o_done, 0);
        for (int k = 0; k < 100 && exp_q.size() > 0; k++) @(negedge clk);
        check_eq("spikes_drained", exp_q.size(), 0);
        check_eq("beats_left", cur_q.size(), extra);
        check_eq("beats_consumed", n_consumed, NC);
        check_eq("write_count", n_writes, NC);
        for (int i = 0; i < NC; i++) check_eq($sformatf("mem%0d", i), mem[i], ref_mem[i]);
        cur_q.delete();
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"}, o_busy, 0);
        check_eq({tag, "_done"}, o_done, 0);
        check_eq({tag, "_in_ready"}, o_in_ready, 0);
        check_eq({tag, "_spike_valid"}, o_spike_valid, 0);
        check_eq({tag, "_spike_addr"}, o_spike_addr, 0);
        check_eq({tag, "_write_en"}, o_mem_write_en, 0);
        check_eq({tag, "_write_addr"}, o_mem_write_addr, 0);
        check_eq({tag, "_write_data"}, o_mem_write_data, 0);
        check_eq({tag, "_read_addr"}, o_mem_read_addr, 0);
        check_eq({tag, "_count"}, o_spike_count, 0);
        check_eq({tag, "_state"}, o_dbg_state, 0);
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
        $fatal(1);
    end

    // Main sequence
    initial begin : main
        bit spk;
        rst_n = 1'b0;
        i_start = 1'b0;
        i_threshold = '0; i_leak = '0; i_reset_v = '0; i_refrac_period = '0;
        set_cfg(0, 0, 0, 0);
        for (int i = 0; i < NC; i++) set_neuron(i, '0);
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_busy", o_busy, 0);
        check_eq("idle_in_ready", o_in_ready, 0);

        // Basic sweep: three sub-threshold neurons, one spike into REFRACT
        set_cfg(10, 1, -5, 3);
        set_cur4(8'd5, 8'd5, 8'd5, 8'd20);
        run_step(7, 0, 0);
        check_eq("t1_v0", mem[0], {8'd4, 8'd0, 2'd0});
        check_eq("t1_n3", mem[3], {8'hFB, 8'd3, 2'd1});

        // Refractory countdown r=2 -> 1 -> 0
        set_neuron(0, {8'd7, 8'd2, 2'd1});
        set_cfg(100, 0, 0, 0);
        rand_cur(0);
        run_step(7, 0, 0);
        check_eq("refrac_r1", mem[0], {8'd7, 8'd1, 2'd1});
        rand_cur(0);
        run_step(7, 0, 0);
        check_eq("refrac_r0", mem[0], {8'd7, 8'd0, 2'd0});

        // Saturation both ways; modes 2 and 3 integrate
        set_neuron(0, {8'd120, 8'd0, 2'd0});
        set_neuron(1, {8'h88, 8'd0, 2'd0});
        set_neuron(2, {8'd3, 8'd0, 2'd2});
        set_neuron(3, {8'd3, 8'd0, 2'd3});
        set_cfg(127, 0, 0, 2);
        set_cur4(8'd127, 8'h9C, 8'd1, 8'd1);
        run_step(7, 0, 0);
        check_eq("sat_hi", mem[0], {8'd0, 8'd2, 2'd1});
        check_eq("sat_lo", mem[1], {8'h80, 8'd0, 2'd0});

        // Spike backpressure: every neuron spikes, sink stalls 5 cycles
        for (int i = 0; i < NC; i++) set_neuron(i, '0);
        set_cfg(0, 0, 0, 0);
        set_cur4(8'd50, 8'd50, 8'd50, 8'd50);
        stall_arm = 1;
        run_step(-1, 0, 0);
        check_eq("stall_happened", stall_arm, 0);

        // Randomized timesteps with valid gaps and random spike-ready
        gap_max = 3;
        rand_ready = 1;
        for (int i = 0; i < NC; i++)
            set_neuron(i, {DW'($urandom_range(0, 255)), DW'($urandom_range(0, 3)),
                           FW'($urandom_range(0, 3))});
        for (int s = 0; s < 6; s++) begin
            set_cfg(int'($urandom_range(0, 60)) - 20, int'($urandom_range(0, 10)),
                    int'($urandom_range(0, 40)) - 30, int'($urandom_range(0, 3)));
            rand_cur(s == 4 ? 2 : 0);
            run_step(-1, s == 4 ? 2 : 0, s == 2);
        end

        // Reset in the middle of a sweep, with neuron 2 in stage 1
        gap_max = 0;
        rand_ready = 0;
        for (int i = 0; i < NC; i++) set_neuron(i, '0);
        set_cfg(100, 0, 0, 0);
        set_cur4(8'd3, 8'd4, 8'd5, 8'd6);
        @(negedge clk);
        cur_q = cur_arr;
        drive_start();
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("midreset");
        repeat (3) begin
            @(negedge clk);
            check_eq("midreset_no_done", o_done, 0);
        end
        cur_q.delete();
        exp_q.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) ref_mem[i] = ref_neuron(ref_mem[i], cur_arr[i], spk);
        for (int i = 0; i < NC; i++) check_eq($sformatf("midreset_mem%0d", i), mem[i], ref_mem[i]);
        set_cfg(5, 1, 0, 1);
        set_cur4(8'd2, 8'd9, 8'd7, 8'd1);
        run_step(7, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/neuron_update_scheduler.md
# neuron_update_scheduler

Sequencer that owns both ports of `neuron_state_memory` and runs one leaky integrate-and-fire timestep over all neurons. On each start pulse it sweeps addresses 0..NEURON_COUNT-1 at one neuron per cycle. For each neuron it merges an input-current stream, applies leak, threshold and refractory rules, writes the new state back, and emits spike addresses under backpressure.

## Interface
- NEURON_COUNT, 10000, neurons swept per timestep
- ADDR_WIDTH, 14, memory address width
- DATA_WIDTH, 8, membrane and refractory field width
- FSM_WIDTH, 2, per-neuron state field width
- clk  input  1  single clock
- rst_n  input  1  synchronous, active-low reset
- i_start  input  1  timestep start pulse; ignored unless IDLE
- i_threshold, i_leak, i_reset_v  input  DATA_WIDTH each  signed threshold, unsigned leak, signed reset potential; latched on accepted start
- i_refrac_period  input  DATA_WIDTH  refractory timesteps, unsigned; latched on start
- i_in_valid  input  1  current-stream valid
- i_in_data  input  DATA_WIDTH  signed current for the next neuron in address order
- o_in_ready  output  1  current consumed when valid&&ready
- o_spike_valid  output  1  spike event valid
- o_spike_addr  output  ADDR_WIDTH  spiking neuron
- i_spike_ready  input  1  spike sink ready
- o_mem_read_addr  output  ADDR_WIDTH  to memory read port
- i_mem_read_data  input  2*DATA_WIDTH+FSM_WIDTH  from memory; valid 1 cycle after address sampled
- o_mem_write_en, o_mem_write_addr, o_mem_write_data  output  1/ADDR_WIDTH/2*DATA_WIDTH+FSM_WIDTH  to memory write port
- o_busy  output  1  sweep in progress
- o_done  output  1  one-cycle pulse at end of timestep
- o_spike_count  output  16  spikes in last completed timestep (saturating)

## Operation
- State word: [MSB -: DATA_WIDTH] = membrane v (signed); next DATA_WIDTH = refractory count r; [FSM_WIDTH-1:0] = mode. Mode 0 = INTEGRATE, 1 = REFRACT; values 2 and 3 are treated as INTEGRATE.
- FSM: IDLE -> SWEEP on i_start. SWEEP -> DRAIN after address NEURON_COUNT-1 is issued. DRAIN -> DONE after the last fire and its write are issued. DONE -> IDLE after one cycle.
- Pipeline stage 0 is the issue pointer ptr. Stage 1 holds s1_valid/s1_addr, aligned with i_mem_read_data.
- fire = s1_valid && i_in_valid && o_in_ready.
- o_in_ready = s1_valid && (!o_spike_valid || i_spike_ready).
- Stage 1 advances when !s1_valid || fire. ptr increments on advance during SWEEP.
- o_mem_read_addr = ptr when stage 1 advances, else s1_addr. The stalled neuron is re-read, so its data stays valid.
- INTEGRATE on fire:
  - t = sat(v - leak + current), saturating to the signed DATA_WIDTH range.
  - If t >= threshold (signed compare): spike; v = reset_v; r = refrac_period; mode = REFRACT if refrac_period != 0, else INTEGRATE.
  - Otherwise: v = t, r and mode unchanged.
- REFRACT on fire: the current is consumed and discarded; v is unchanged.
  - If r <= 1: r = 0, mode = INTEGRATE.
  - Otherwise: r = r - 1.
- Write and spike outputs are registered and appear the cycle after fire.
- Spike output holds while !i_spike_ready. It clears on a handshake with no new spike.
- o_spike_count resets to 0 on start, increments per spike, and saturates at 65535.

## Timing
- Reset: all outputs 0, FSM IDLE, ptr 0, s1_valid 0, config registers 0. Memory contents are untouched.
- Reset mid-sweep abandons the timestep. Neurons already written keep their new state; no done pulse is issued.
- Start edge: o_busy rises the next cycle and read address 0 is presented in that cycle. First fire is possible 1 cycle later.
- Throughput: 1 neuron/cycle with no stalls. A timestep takes NEURON_COUNT+3 cycles from start to the o_done pulse.
- o_busy is high in SWEEP and DRAIN. o_done pulses in DONE with o_busy low. i_start is accepted again the cycle after DONE.
- Each address is written at most once per sweep, so there is no read-after-write hazard. The final write completes before o_done.
- i_start while busy is ignored, with no effect on config or count.
- NEURON_COUNT = 1: SWEEP lasts 1 cycle, then DRAIN.
- An input beat is never consumed without a matching stage-1 neuron. Extra beats after the sweep stay unconsumed.

## Test plan
- NEURON_COUNT=4, all states 0, threshold 10, leak 1, currents 5,5,5,20 with no stalls:
  - Writes v=4,4,4 for neurons 0–2.
  - Neuron 3 spikes (addr 3); its state becomes reset_v with mode REFRACT, r = refrac_period.
  - o_done at start+7; o_spike_count = 1.
- Neuron in REFRACT with r=2: two timesteps give r=1 then r=0 and mode INTEGRATE, with v constant and currents consumed.
- Saturation: v=120, current 127, leak 0, threshold 127 -> t=127, spike.
  - Negative check: v=-120, current -100 -> v=-128, no spike.
- i_spike_ready held low 5 cycles after the first spike, with a second spike pending:
  - o_in_ready stays 0 and o_mem_read_addr equals s1_addr for the whole stall.
  - No write is issued; resumed data is correct.
- i_in_valid gaps of random length: states match the reference model and each current is consumed exactly once.
- rst_n low in mid-sweep at neuron 2:
  - All outputs 0 next cycle, no o_done.
  - A new start re-sweeps from address 0, using the partially updated memory.
